// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
//   tx_state_t : transmit FSM states
//   ST_*       : bit positions inside the status byte returned on loads
//   baud_div   : clocks per bit period (truncating division)
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int unsigned ST_BUSY = 0;
   localparam int unsigned ST_FULL = 1;
   localparam int unsigned ST_OVF  = 2;

   function automatic int unsigned baud_div(input int unsigned clk_hz,
                                            input int unsigned baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a fall-through read port.
//   clk, rst : clock, asynchronous active-low reset
//   push/din : write din when not full (or when full and popping this cycle)
//   pop/dout : dout shows the head entry; pop advances past it
//   full, empty, count : occupancy status
module sync_fifo #(
   parameter int unsigned N     = 8,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [N-1:0]             din,
   output logic [N-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [N-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty = (wr_ptr == rd_ptr);
   // One extra pointer bit distinguishes full from empty when the indices match.
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign dout  = mem[rd_ptr[AW-1:0]];

   assign do_pop  = pop & ~empty;
   // When full, a simultaneous pop frees the head slot that the push overwrites.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_mmio_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the processor store bus.
//   clk, rst          : clock, asynchronous active-low reset
//   cpu_tick          : one-clk strobe; store bus sampled only when high
//   addr, wdata, we   : processor data address, store data, MemWrite
//   sel               : addr hits DATA_ADDR or STAT_ADDR
//   rdata             : status byte {5'b0, overflow, full, busy}
//   txd               : registered serial output, idle high
//   busy, overflow    : transmitter active / sticky dropped-store flag
module uart_mmio_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50000000,
   parameter int unsigned BAUD      = 115200,
   parameter int unsigned DEPTH     = 8,
   parameter logic [7:0]  DATA_ADDR = 8'hFF,
   parameter logic [7:0]  STAT_ADDR = 8'hFE
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_tick,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic       we,
   output logic       sel,
   output logic [7:0] rdata,
   output logic       txd,
   output logic       busy,
   output logic       overflow
);

   localparam int unsigned DIV = baud_div(CLK_HZ, BAUD);
   localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

   tx_state_t                state;
   logic [7:0]               shift;
   logic [CW-1:0]            baud_cnt;
   logic [2:0]               bit_idx;
   logic                     push_req;
   logic                     clr_req;
   logic                     pop;
   logic                     drop;
   logic [7:0]               fifo_dout;
   logic                     fifo_full;
   logic                     fifo_empty;
   logic [$clog2(DEPTH):0]   fifo_count;
   logic                     bit_end;

   assign sel      = (addr == DATA_ADDR) || (addr == STAT_ADDR);
   assign push_req = cpu_tick & we & (addr == DATA_ADDR);
   assign clr_req  = cpu_tick & we & (addr == STAT_ADDR);
   assign pop      = (state == IDLE) & ~fifo_empty;
   assign drop     = push_req & fifo_full & ~pop;
   assign busy     = (state != IDLE) | (fifo_count != '0);
   assign bit_end  = (baud_cnt == DIV_M1);

   always_comb begin
      rdata          = '0;
      rdata[ST_BUSY] = busy;
      rdata[ST_FULL] = fifo_full;
      rdata[ST_OVF]  = overflow;
   end

   sync_fifo #(
      .N     (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_req),
      .pop   (pop),
      .din   (wdata),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
      end else if (clr_req) begin
         overflow <= 1'b0;
      end
   end

   // txd is loaded with the level of the state being entered, so each bit
   // appears on the line on the same edge the state changes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         txd      <= 1'b1;
         shift    <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               txd <= 1'b1;
               if (!fifo_empty) begin
                  shift    <= fifo_dout;
                  baud_cnt <= '0;
                  state    <= START;
                  txd      <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  state    <= DATA;
                  txd      <= shift[0];
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                     txd   <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     txd     <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
                  txd      <= 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               txd   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mmio_tx.sv
module tb_uart_mmio_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cpu_tick = 1'b0;
   logic [7:0] addr = 8'h00;
   logic [7:0] wdata = 8'h00;
   logic       we = 1'b0;
   logic       sel;
   logic [7:0] rdata;
   logic       txd;
   logic       busy;
   logic       overflow;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   logic [7:0] rx_q[$];
   time        start_q[$];
   logic       mon_en = 1'b0;

   always #5 clk = ~clk;

   uart_mmio_tx #(
      .CLK_HZ    (1000),
      .BAUD      (100),
      .DEPTH     (8),
      .DATA_ADDR (8'hFF),
      .STAT_ADDR (8'hFE)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cpu_tick (cpu_tick),
      .addr     (addr),
      .wdata    (wdata),
      .we       (we),
      .sel      (sel),
      .rdata    (rdata),
      .txd      (txd),
      .busy     (busy),
      .overflow (overflow)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Drives one cpu_tick store; returns at the negedge after the sampling edge.
   task automatic tick_store(input logic [7:0] a, input logic [7:0] d);
      @(negedge clk);
      cpu_tick = 1'b1; we = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      cpu_tick = 1'b0; we = 1'b0; addr = 8'h00;
   endtask

   // Serial decoder: samples mid-bit (DIV = 10 clks) after a falling edge.
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (mon_en && txd === 1'b0) begin
            start_q.push_back($time);
            repeat (4) @(negedge clk);
            check_eq("mon_start_mid", txd, 1'b0);
            for (int i = 0; i < 8; i++) begin
               repeat (10) @(negedge clk);
               b[i] = txd;
            end
            repeat (10) @(negedge clk);
            if (mon_en) begin
               check_eq("mon_stop_bit", txd, 1'b1);
               rx_q.push_back(b);
            end
         end
      end
   end

   initial begin
      logic [9:0] frame;
      int unsigned low_cnt;

      // Reset
      repeat (5) @(negedge clk);
      check_eq("rst_txd", txd, 1'b1);
      check_eq("rst_busy", busy, 1'b0);
      check_eq("rst_rdata", rdata, 8'h00);
      rst = 1'b1;
      mon_en = 1'b1;
      repeat (3) @(negedge clk);

      // Single byte A5, cycle-accurate line check
      frame = {1'b1, 8'hA5, 1'b0};
      tick_store(8'hFF, 8'hA5);
      check_eq("a5_pre_start", txd, 1'b1);
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if ((i % 10) == 1 || (i % 10) == 0)
            check_eq($sformatf("a5_bit%0d_s%0d", (i - 1) / 10, i), txd, frame[(i - 1) / 10]);
         if (i == 50) check_eq("a5_busy_mid", busy, 1'b1);
      end
      @(negedge clk);
      check_eq("a5_busy_end", busy, 1'b0);
      check_eq("a5_txd_idle", txd, 1'b1);
      repeat (5) @(negedge clk);
      check_eq("a5_rx_cnt", rx_q.size(), 1);
      if (rx_q.size() > 0) check_eq("a5_rx_byte", rx_q[0], 8'hA5);
      rx_q.delete();
      start_q.delete();

      // Back-to-back frames
      tick_store(8'hFF, 8'h01);
      tick_store(8'hFF, 8'h80);
      repeat (240) @(negedge clk);
      check_eq("b2b_rx_cnt", rx_q.size(), 2);
      if (rx_q.size() == 2) begin
         check_eq("b2b_byte0", rx_q[0], 8'h01);
         check_eq("b2b_byte1", rx_q[1], 8'h80);
      end
      if (start_q.size() == 2)
         check_eq("b2b_start_gap", 32'(start_q[1] - start_q[0]), 32'd1010);
      else
         check_eq("b2b_start_cnt", start_q.size(), 2);
      check_eq("b2b_busy_end", busy, 1'b0);
      rx_q.delete();
      start_q.delete();

      // Gating and decode, line idle
      @(negedge clk);
      we = 1'b1; addr = 8'hFF; wdata = 8'h55;
      @(negedge clk);
      check_eq("gate_sel", sel, 1'b1);
      we = 1'b0; addr = 8'h00;
      @(negedge clk);
      check_eq("gate_no_push", busy, 1'b0);
      @(negedge clk);
      cpu_tick = 1'b1; we = 1'b1; addr = 8'h10; wdata = 8'h66;
      #1 check_eq("dec_sel_10", sel, 1'b0);
      @(negedge clk);
      cpu_tick = 1'b0; we = 1'b0; addr = 8'h00;
      @(negedge clk);
      check_eq("dec_no_push", busy, 1'b0);
      check_eq("dec_txd", txd, 1'b1);

      // Overflow: 00 pops at once, 01..08 fill the FIFO
      for (int i = 0; i < 9; i++) tick_store(8'hFF, 8'(i));
      addr = 8'hFE;
      #1 check_eq("full_sel", sel, 1'b1);
      check_eq("full_rdata", rdata, 8'h03);
      tick_store(8'hFF, 8'h09);
      check_eq("ovf_flag", overflow, 1'b1);
      addr = 8'hFE;
      #1 check_eq("ovf_rdata", rdata, 8'h07);

      // Clear overflow; FIFO stays full
      tick_store(8'hFE, 8'h5A);
      addr = 8'hFE;
      #1 check_eq("clr_rdata", rdata, 8'h03);
      check_eq("clr_flag", overflow, 1'b0);
      addr = 8'h00;
      repeat (960) @(negedge clk);
      check_eq("ovf_rx_cnt", rx_q.size(), 9);
      for (int i = 0; i < 9; i++)
         if (i < rx_q.size()) check_eq($sformatf("ovf_rx%0d", i), rx_q[i], 8'(i));
      check_eq("ovf_busy_end", busy, 1'b0);

      // Reset mid-frame
      rx_q.delete();
      tick_store(8'hFF, 8'h3C);
      tick_store(8'hFF, 8'hC3);
      repeat (30) @(negedge clk);
      check_eq("mid_busy", busy, 1'b1);
      mon_en = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_txd", txd, 1'b1);
      check_eq("mid_rst_busy", busy, 1'b0);
      check_eq("mid_rst_rdata", rdata, 8'h00);
      rst = 1'b1;
      low_cnt = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (txd !== 1'b1) low_cnt++;
      end
      check_eq("mid_no_resend", low_cnt, 0);
      check_eq("mid_idle_busy", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
